seq_restoring_divider: RTL and testbench

//  Multi-cycle restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.

---
 rtl/seq_div_pkg.sv | 14 +
 rtl/div_trial_sub.sv | 22 ++
 rtl/seq_restoring_divider.sv | 169 ++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int   DIV_WIDTH_DEFAULT = 8;
   localparam logic OP_ADD            = 1'b0;
   localparam logic OP_SUB            = 1'b1;

endpackage

// File: rtl/div_trial_sub.sv
// WIDTH+1-bit add/sub slice used for the trial subtraction; borrow is the
// inverted carry-out when subtracting, the plain carry-out when adding.
module div_trial_sub
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   input  logic           opcode,
   output logic [WIDTH:0] diff,
   output logic           borrow
);

   logic [WIDTH:0] b_eff;
   logic           carry;

   assign b_eff = b ^ {(WIDTH+1){opcode}};
   assign {carry, diff} = {1'b0, a} + {1'b0, b_eff} + {{(WIDTH+1){1'b0}}, opcode};
   assign borrow = carry ^ opcode;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands and results.
module seq_restoring_divider
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t       state;
   div_state_t       state_next;
   logic             accept;
   logic             iterate;
   logic             finish;
   logic [CNT_W-1:0] iter_cnt;

   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] part_rem;
   logic [WIDTH-1:0] dsr_mag;
   logic             zero_dsr;

   logic [WIDTH-1:0] dvd_in;
   logic [WIDTH-1:0] dsr_in;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   trial_diff;
   logic             trial_borrow;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_final;
   logic [WIDTH-1:0] r_final;
   logic             unused_diff_msb;

`ifdef SEQ_DIV_SIGNED_EN
   logic neg_q;
   logic neg_r;

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      // The most-negative value maps onto its own bit pattern, read as unsigned.
      return v[WIDTH-1] ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
      return neg ? -mag : mag;
   endfunction

   assign dvd_in  = magnitude(dividend);
   assign dsr_in  = magnitude(divisor);
   assign q_final = zero_dsr ? {WIDTH{1'b1}} : apply_sign(q_next, neg_q);
   assign r_final = apply_sign(r_next, neg_r);
`else
   assign dvd_in  = dividend;
   assign dsr_in  = divisor;
   assign q_final = q_next;
   assign r_final = r_next;
`endif

   // Trial subtraction: shift the next dividend bit into the partial remainder.
   assign rem_shift = {part_rem, work_q[WIDTH-1]};

   div_trial_sub #(
      .WIDTH(WIDTH)
   ) u_trial_sub (
      .a      (rem_shift),
      .b      ({1'b0, dsr_mag}),
      .opcode (OP_SUB),
      .diff   (trial_diff),
      .borrow (trial_borrow)
   );

   // Without a borrow the difference is below the divisor, so its MSB is always zero.
   assign unused_diff_msb = trial_diff[WIDTH];
   assign q_next = {work_q[WIDTH-2:0], ~trial_borrow};
   assign r_next = trial_borrow ? rem_shift[WIDTH-1:0] : trial_diff[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      iterate    = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            iterate = 1'b1;
            if (iter_cnt == LAST_CNT) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         iter_cnt <= '0;
      end else if (accept) begin
         iter_cnt <= '0;
      end else if (iterate) begin
         iter_cnt <= iter_cnt + CNT_W'(1);
      end
   end

   // Working registers carry no reset: they are always reloaded at accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         work_q   <= dvd_in;
         part_rem <= '0;
         dsr_mag  <= dsr_in;
         zero_dsr <= (divisor == '0);
`ifdef SEQ_DIV_SIGNED_EN
         neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         neg_r    <= dividend[WIDTH-1];
`endif
      end else if (iterate) begin
         work_q   <= q_next;
         part_rem <= r_next;
      end
   end

   // Result registers load on the last iteration and hold through DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (finish) begin
         quotient    <= q_final;
         remainder   <= r_final;
         div_by_zero <= zero_dsr;
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8); honours SEQ_DIV_SIGNED_EN.
module tb_seq_restoring_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } vec_t;

   vec_t tbl[$];

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, want);
      end
   endtask

   // Reference: plain division arithmetic with the documented special cases.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic z);
`ifdef SEQ_DIV_SIGNED_EN
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      z  = (b == 0);
      if (b == 0) begin
         q = '1;
         r = a;
      end else begin
         q = W'(sa / sb);
         r = W'(sa % sb);
      end
`else
      z = (b == 0);
      if (b == 0) begin
         q = '1;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
`endif
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk); #1;
      // Keep in_valid high with junk operands: must be ignored while busy.
      dividend = W'($urandom);
      divisor  = W'($urandom);
      n = 0;
      while (!out_valid && n < 3 * W) begin
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      check({tag, " latency"}, 32'(n), 32'(W));
      check({tag, " result"}, {in_ready, quotient, remainder, div_by_zero}, {1'b0, eq, er, ez});
      repeat (hold) begin
         @(posedge clk); #1;
         check({tag, " hold"}, {out_valid, in_ready, quotient, remainder, div_by_zero},
               {1'b1, 1'b0, eq, er, ez});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " release"}, {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      logic [W-1:0] ra, rb, mq, mr;
      logic         mz;

      tbl.push_back('{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  z: 1'b0});
      tbl.push_back('{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  z: 1'b0});
      tbl.push_back('{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  z: 1'b0});
      tbl.push_back('{a: 8'd37,  b: 8'd0,   q: 8'hFF,  r: 8'd37, z: 1'b1});
      tbl.push_back('{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  z: 1'b0});
      tbl.push_back('{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,  z: 1'b0});
`ifdef SEQ_DIV_SIGNED_EN
      tbl.push_back('{a: 8'hF9, b: 8'd2,   q: 8'hFD, r: 8'hFF, z: 1'b0});
      tbl.push_back('{a: 8'd7,  b: 8'hFE,  q: 8'hFD, r: 8'd1,  z: 1'b0});
      tbl.push_back('{a: 8'h80, b: 8'hFF,  q: 8'h80, r: 8'd0,  z: 1'b0});
      tbl.push_back('{a: 8'hFB, b: 8'd0,   q: 8'hFF, r: 8'hFB, z: 1'b1});
      tbl.push_back('{a: 8'h80, b: 8'd3,   q: 8'hD6, r: 8'hFE, z: 1'b0});
      tbl.push_back('{a: 8'h7F, b: 8'h80,  q: 8'd0,  r: 8'h7F, z: 1'b0});
`else
      tbl.push_back('{a: 8'd254, b: 8'd127, q: 8'd2,  r: 8'd0,  z: 1'b0});
      tbl.push_back('{a: 8'd128, b: 8'd3,   q: 8'd42, r: 8'd2,  z: 1'b0});
      tbl.push_back('{a: 8'd255, b: 8'd16,  q: 8'd15, r: 8'd15, z: 1'b0});
`endif

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("reset_state", {in_ready, out_valid, quotient, remainder, div_by_zero},
            {1'b1, 1'b0, 8'd0, 8'd0, 1'b0});

      run_op(8'd100, 8'd7, 5, "hold_100_7", 8'd14, 8'd2, 1'b0);

      for (int i = 0; i < tbl.size(); i++)
         run_op(tbl[i].a, tbl[i].b, i % 3, $sformatf("vec%0d", i), tbl[i].q, tbl[i].r, tbl[i].z);

      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         if (i == 0) begin
            ra = 8'h80;
            rb = 8'hFF;
         end
         model(ra, rb, mq, mr, mz);
         run_op(ra, rb, $urandom_range(0, 2), $sformatf("rand%0d_%0h_%0h", i, ra, rb), mq, mr, mz);
      end

      // Leave nonzero results in the output registers, then abort a run mid-way.
      run_op(8'd37, 8'd0, 0, "pre_abort", 8'hFF, 8'd37, 1'b1);
      in_valid = 1'b1;
      dividend = 8'd200;
      divisor  = 8'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_state", {in_ready, out_valid, quotient, remainder, div_by_zero},
            {1'b1, 1'b0, 8'd0, 8'd0, 1'b0});
      repeat (W + 2) begin
         @(posedge clk); #1;
         check("abort_no_result", 32'(out_valid), 32'd0);
      end
      run_op(8'd12, 8'd4, 1, "after_abort", 8'd3, 8'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
